// File: rtl/eval_dispatch.sv
// eval_dispatch: initiator side of the board-evaluation handshake.
// Takes one position per request, runs board_attack then evaluate, returns
// the captured score/flags over a valid/ready port, then clears both engines.
// Optional: EVAL_DISPATCH_TIMEOUT_EN bounds both wait states by TIMEOUT_CYCLES.
`ifndef PIECE_WIDTH
`define PIECE_WIDTH 4
`endif
`ifndef BOARD_WIDTH
`define BOARD_WIDTH (64*`PIECE_WIDTH)
`endif

module eval_dispatch #(
  parameter int EVAL_WIDTH     = 24,
  parameter int UCI_WIDTH      = 16,
  parameter int BOARD_WIDTH    = `BOARD_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  // request from search controller
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [BOARD_WIDTH-1:0] req_board,
  input  logic                   req_white_to_move,
  input  logic [3:0]             req_castle_mask,
  input  logic [UCI_WIDTH-1:0]   req_uci,
  // registered position to the engines
  output logic [BOARD_WIDTH-1:0] board,
  output logic                   white_to_move,
  output logic [3:0]             castle_mask,
  output logic [UCI_WIDTH-1:0]   uci,
  // board_attack
  output logic                   attack_board_valid,
  input  logic                   is_attacking_done,
  input  logic                   white_in_check,
  input  logic                   black_in_check,
  output logic                   clear_attack,
  // evaluate
  output logic                   eval_board_valid,
  input  logic                   eval_valid,
  input  logic [EVAL_WIDTH-1:0]  eval,
  input  logic                   insufficient_material,
  output logic                   clear_eval,
  // result
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [EVAL_WIDTH-1:0]  res_eval,
  output logic                   res_white_in_check,
  output logic                   res_black_in_check,
  output logic                   res_insufficient,
  output logic                   res_timeout
);

  typedef enum logic [2:0] {
    IDLE, ATTACK_WAIT, EVAL_WAIT, RESULT, CLEAR
  } state_t;

  typedef struct packed {
    logic                  white_chk;
    logic                  black_chk;
    logic                  insufficient;
    logic [EVAL_WIDTH-1:0] score;
  } res_t;

  state_t state, state_nxt;
  res_t   res_q;
  logic   accept;
  logic   to_hit;

  assign accept = (state == IDLE) && req_valid;

`ifdef EVAL_DISPATCH_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_q;

  assign to_hit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts on every state change, runs only while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (state == ATTACK_WAIT || state == EVAL_WAIT)
      wait_cnt <= wait_cnt + 16'd1;
  end

  // Timeout flag: set when a wait expires, cleared by the next request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      timeout_q <= 1'b0;
    else if (accept) timeout_q <= 1'b0;
    else if (to_hit && ((state == ATTACK_WAIT && !is_attacking_done) ||
                        (state == EVAL_WAIT && !eval_valid)))
      timeout_q <= 1'b1;
  end

  assign res_timeout = timeout_q;
`else
  assign to_hit      = 1'b0;
  assign res_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_nxt          = state;
    req_ready          = 1'b0;
    attack_board_valid = 1'b0;
    eval_board_valid   = 1'b0;
    res_valid          = 1'b0;
    clear_attack       = 1'b0;
    clear_eval         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ATTACK_WAIT;
      end
      ATTACK_WAIT: begin
        attack_board_valid = 1'b1;
        if (is_attacking_done) state_nxt = EVAL_WAIT;
        else if (to_hit)       state_nxt = RESULT;
      end
      EVAL_WAIT: begin
        eval_board_valid = 1'b1;
        if (eval_valid)  state_nxt = RESULT;
        else if (to_hit) state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = CLEAR;
      end
      CLEAR: begin
        clear_attack = 1'b1;
        clear_eval   = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position registers, loaded on request acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board         <= '0;
      white_to_move <= 1'b0;
      castle_mask   <= '0;
      uci           <= '0;
    end else if (accept) begin
      board         <= req_board;
      white_to_move <= req_white_to_move;
      castle_mask   <= req_castle_mask;
      uci           <= req_uci;
    end
  end

  // Result capture; a timeout leaves score and flags at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
    end else if (accept) begin
      res_q <= '0;
    end else if (state == ATTACK_WAIT) begin
      if (is_attacking_done) begin
        res_q.white_chk <= white_in_check;
        res_q.black_chk <= black_in_check;
      end else if (to_hit) begin
        res_q <= '0;
      end
    end else if (state == EVAL_WAIT) begin
      if (eval_valid) begin
        res_q.score        <= eval;
        res_q.insufficient <= insufficient_material;
      end else if (to_hit) begin
        res_q <= '0;
      end
    end
  end

  assign res_eval           = res_q.score;
  assign res_white_in_check = res_q.white_chk;
  assign res_black_in_check = res_q.black_chk;
  assign res_insufficient   = res_q.insufficient;

endmodule

// File: tb/tb_eval_dispatch.sv
// Directed self-checking bench for eval_dispatch.
// Timeout scenario is built only with EVAL_DISPATCH_TIMEOUT_EN.
module tb_eval_dispatch;
  localparam int EW = 24;
  localparam int UW = 16;
  localparam int BW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [BW-1:0] req_board = '0;
  logic          req_white_to_move = 1'b0;
  logic [3:0]    req_castle_mask = '0;
  logic [UW-1:0] req_uci = '0;
  logic [BW-1:0] board;
  logic          white_to_move;
  logic [3:0]    castle_mask;
  logic [UW-1:0] uci;
  logic          attack_board_valid;
  logic          is_attacking_done = 1'b0;
  logic          white_in_check = 1'b0;
  logic          black_in_check = 1'b0;
  logic          clear_attack;
  logic          eval_board_valid;
  logic          eval_valid = 1'b0;
  logic [EW-1:0] eval = '0;
  logic          insufficient_material = 1'b0;
  logic          clear_eval;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [EW-1:0] res_eval;
  logic          res_white_in_check;
  logic          res_black_in_check;
  logic          res_insufficient;
  logic          res_timeout;

  int errors = 0;
  int checks = 0;

  eval_dispatch #(.EVAL_WIDTH(EW), .UCI_WIDTH(UW), .BOARD_WIDTH(BW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_board(req_board),
    .req_white_to_move(req_white_to_move), .req_castle_mask(req_castle_mask), .req_uci(req_uci),
    .board(board), .white_to_move(white_to_move), .castle_mask(castle_mask), .uci(uci),
    .attack_board_valid(attack_board_valid), .is_attacking_done(is_attacking_done),
    .white_in_check(white_in_check), .black_in_check(black_in_check), .clear_attack(clear_attack),
    .eval_board_valid(eval_board_valid), .eval_valid(eval_valid), .eval(eval),
    .insufficient_material(insufficient_material), .clear_eval(clear_eval),
    .res_valid(res_valid), .res_ready(res_ready), .res_eval(res_eval),
    .res_white_in_check(res_white_in_check), .res_black_in_check(res_black_in_check),
    .res_insufficient(res_insufficient), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept a request and wait n cycles before signalling attack done.
  task automatic launch(input logic [BW-1:0] b, input int attack_lat,
                        input logic wchk, input logic bchk);
    req_board = b; req_white_to_move = 1'b1; req_castle_mask = 4'hA; req_uci = 16'h1234;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle(attack_lat - 1);
    is_attacking_done = 1'b1; white_in_check = wchk; black_in_check = bchk;
    cycle();
    is_attacking_done = 1'b0; white_in_check = 1'b0; black_in_check = 1'b0;
  endtask

  // In EVAL_WAIT: wait then deliver a score.
  task automatic deliver(input int eval_lat, input logic [EW-1:0] e, input logic ins);
    cycle(eval_lat - 1);
    eval_valid = 1'b1; eval = e; insufficient_material = ins;
    cycle();
    eval_valid = 1'b0; eval = '0; insufficient_material = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycle(2);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    checks++; if ({attack_board_valid, eval_board_valid, res_valid, clear_attack, clear_eval, res_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000",
        {attack_board_valid, eval_board_valid, res_valid, clear_attack, clear_eval, res_timeout}); end
    checks++; if ({board, white_to_move, castle_mask, uci, res_eval} !== '0) begin
      errors++; $display("FAIL reset_regs nonzero board=%0h uci=%0h res_eval=%0h", board, uci, res_eval); end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    logic [BW-1:0] b;
    b = {8{32'hC0FFEE01}};
    res_ready = 1'b1;
    req_board = b; req_white_to_move = 1'b1; req_castle_mask = 4'hA; req_uci = 16'h1234;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    checks++; if ({attack_board_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL basic_attack_launch got %b exp 10", {attack_board_valid, req_ready}); end
    checks++; if ({board, white_to_move, castle_mask, uci} !== {b, 1'b1, 4'hA, 16'h1234}) begin
      errors++; $display("FAIL basic_board_regs got uci=%0h castle=%0h exp uci=1234 castle=a", uci, castle_mask); end
    cycle(4);
    is_attacking_done = 1'b1;
    cycle();
    is_attacking_done = 1'b0;
    checks++; if ({attack_board_valid, eval_board_valid} !== 2'b01) begin errors++; $display("FAIL basic_eval_launch got %b exp 01", {attack_board_valid, eval_board_valid}); end
    deliver(8, 24'd37, 1'b0);
    checks++; if (res_valid !== 1'b1 || res_eval !== 24'd37) begin errors++; $display("FAIL basic_result got v=%0b e=%0d exp v=1 e=37", res_valid, res_eval); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL basic_no_timeout got %0b exp 0", res_timeout); end
    cycle();
    checks++; if ({res_valid, clear_attack, clear_eval, req_ready} !== 4'b0110) begin
      errors++; $display("FAIL basic_clear got %b exp 0110", {res_valid, clear_attack, clear_eval, req_ready}); end
    cycle();
    checks++; if ({clear_attack, clear_eval, req_ready} !== 3'b001) begin
      errors++; $display("FAIL basic_back_idle got %b exp 001", {clear_attack, clear_eval, req_ready}); end
  endtask

  task automatic test_negative();
    res_ready = 1'b1;
    launch({8{32'h11112222}}, 2, 1'b0, 1'b1);
    deliver(3, -24'sd1200, 1'b1);
    checks++; if (res_eval !== 24'hFFFB50) begin errors++; $display("FAIL neg_score got %0h exp fffb50", res_eval); end
    checks++; if ({res_white_in_check, res_black_in_check, res_insufficient} !== 3'b011) begin
      errors++; $display("FAIL neg_flags got %b exp 011", {res_white_in_check, res_black_in_check, res_insufficient}); end
    cycle(2);
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] b2;
    int bad;
    b2 = {8{32'h0BADF00D}};
    res_ready = 1'b0;
    launch({8{32'h33334444}}, 1, 1'b1, 1'b0);
    deliver(1, 24'h00ABCD, 1'b0);
    req_board = b2; req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_eval !== 24'h00ABCD || req_ready !== 1'b0 || res_white_in_check !== 1'b1) bad++;
      cycle();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    res_ready = 1'b1;
    cycle();
    checks++; if ({clear_attack, req_ready, res_valid} !== 3'b100) begin errors++; $display("FAIL bp_clear got %b exp 100", {clear_attack, req_ready, res_valid}); end
    cycle();
    checks++; if ({req_ready, attack_board_valid} !== 2'b10) begin errors++; $display("FAIL bp_idle got %b exp 10", {req_ready, attack_board_valid}); end
    cycle();
    req_valid = 1'b0;
    checks++; if (attack_board_valid !== 1'b1 || board !== b2) begin errors++; $display("FAIL bp_second_req got abv=%0b board=%0h", attack_board_valid, board[31:0]); end
    is_attacking_done = 1'b1; cycle(); is_attacking_done = 1'b0;
    deliver(1, 24'd1, 1'b0);
    cycle(2);
  endtask

  task automatic test_spurious();
    res_ready = 1'b1;
    is_attacking_done = 1'b1; cycle(); is_attacking_done = 1'b0;
    checks++; if ({req_ready, attack_board_valid, eval_board_valid, res_valid} !== 4'b1000) begin
      errors++; $display("FAIL spur_idle got %b exp 1000", {req_ready, attack_board_valid, eval_board_valid, res_valid}); end
    req_valid = 1'b1; cycle(); req_valid = 1'b0;
    eval_valid = 1'b1; eval = 24'd99; cycle(); eval_valid = 1'b0; eval = '0;
    checks++; if ({attack_board_valid, eval_board_valid, res_valid} !== 3'b100) begin
      errors++; $display("FAIL spur_attack got %b exp 100", {attack_board_valid, eval_board_valid, res_valid}); end
    is_attacking_done = 1'b1; cycle(); is_attacking_done = 1'b0;
    deliver(2, 24'd5, 1'b0);
    checks++; if (res_valid !== 1'b1 || res_eval !== 24'd5) begin errors++; $display("FAIL spur_result got v=%0b e=%0d exp v=1 e=5", res_valid, res_eval); end
    cycle(2);
  endtask

  task automatic test_midreset();
    res_ready = 1'b0;
    launch({8{32'h55556666}}, 1, 1'b0, 1'b0);
    cycle(2);
    checks++; if (eval_board_valid !== 1'b1) begin errors++; $display("FAIL mr_in_eval got %0b exp 1", eval_board_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({eval_board_valid, res_valid, req_ready, clear_eval, clear_attack} !== 5'b00100) begin
      errors++; $display("FAIL mr_abort got %b exp 00100", {eval_board_valid, res_valid, req_ready, clear_eval, clear_attack}); end
    checks++; if (board !== '0) begin errors++; $display("FAIL mr_board got %0h exp 0", board[31:0]); end
    #1 reset = 1'b1;
    cycle();
    checks++; if ({req_ready, clear_attack} !== 2'b10) begin errors++; $display("FAIL mr_idle got %b exp 10", {req_ready, clear_attack}); end
  endtask

`ifdef EVAL_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    res_ready = 1'b0;
    launch({8{32'h77778888}}, 1, 1'b1, 1'b1);
    early = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (res_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early got %0d exp 0", early); end
    cycle();
    checks++; if ({res_valid, res_timeout} !== 2'b11 || res_eval !== '0) begin
      errors++; $display("FAIL to_result got v=%0b t=%0b e=%0h exp 1 1 0", res_valid, res_timeout, res_eval); end
    checks++; if ({res_white_in_check, res_black_in_check, res_insufficient} !== 3'b000) begin
      errors++; $display("FAIL to_flags got %b exp 000", {res_white_in_check, res_black_in_check, res_insufficient}); end
    res_ready = 1'b1;
    cycle();
    checks++; if ({clear_attack, clear_eval} !== 2'b11) begin errors++; $display("FAIL to_clear got %b exp 11", {clear_attack, clear_eval}); end
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_spurious();
    test_midreset();
`ifdef EVAL_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/eval_dispatch.md
Name: eval_dispatch

Overview:
- Initiator side of the board-evaluation handshake.
- Accepts one board position per request from the search controller and drives board_attack first.
- After board_attack completes, drives evaluate with the attack results and captures the signed score.
- Returns the score and check/material flags over a valid/ready result port, then clears both engines before accepting the next request.

Parameters:
- EVAL_WIDTH, 24, signed score width.
- UCI_WIDTH, 16, move encoding width (promotion 4, to 6, from 6).
- BOARD_WIDTH, `BOARD_WIDTH, packed board width (64 × `PIECE_WIDTH).
- TIMEOUT_CYCLES, 1024, wait-state limit; used only with EVAL_DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request board valid.
- req_ready  out  1  block idle and can accept a request.
- req_board  in  BOARD_WIDTH  position to evaluate.
- req_white_to_move  in  1  side to move.
- req_castle_mask  in  4  castle rights.
- req_uci  in  UCI_WIDTH  move that produced the position.
- board  out  BOARD_WIDTH  registered board to board_attack and evaluate.
- white_to_move, castle_mask[3:0], uci  out  registered copies to evaluate.
- attack_board_valid  out  1  launches board_attack.
- is_attacking_done  in  1  board_attack complete.
- white_in_check, black_in_check  in  1  from board_attack.
- clear_attack  out  1  one-cycle clear to board_attack.
- eval_board_valid  out  1  launches evaluate.
- eval_valid  in  1  evaluate complete.
- eval  in  EVAL_WIDTH  signed score.
- insufficient_material  in  1  from evaluate.
- clear_eval  out  1  one-cycle clear to evaluate.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_eval  out  EVAL_WIDTH  captured score.
- res_white_in_check, res_black_in_check, res_insufficient  out  1  captured flags.
- res_timeout  out  1  result aborted by timeout.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0 except req_ready=1. board, white_to_move, castle_mask and uci are cleared to 0.
- States: IDLE → ATTACK_WAIT → EVAL_WAIT → RESULT → CLEAR → IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, register board, white_to_move, castle_mask and uci; go to ATTACK_WAIT.
- ATTACK_WAIT:
  - attack_board_valid=1 (level).
  - When is_attacking_done is sampled 1: capture white_in_check and black_in_check into the result registers, deassert attack_board_valid on the next cycle, go to EVAL_WAIT.
- EVAL_WAIT:
  - eval_board_valid=1 (level).
  - When eval_valid is sampled 1: capture eval and insufficient_material, go to RESULT.
- RESULT:
  - res_valid=1, with all res_* outputs stable.
  - On res_ready, go to CLEAR.
- CLEAR:
  - clear_attack=1 and clear_eval=1 for exactly one cycle, then IDLE.
- Minimum latency, acceptance to res_valid: 2 + attack latency + eval latency cycles.
- eval_valid arriving in ATTACK_WAIT is ignored. Done/valid pulses arriving in IDLE or RESULT are ignored.
- req_ready=0 in every state except IDLE: exactly one request is in flight.
- res_eval is stored sign-intact at EVAL_WIDTH with no truncation or extension.
- Reset asserted mid-operation aborts immediately to IDLE. No clear pulse is issued; downstream engines share the same reset.
- A res_ready already high when RESULT is entered completes the handshake in that same cycle (res_valid is high for 1 cycle).

Optional Feature:
- Macro: EVAL_DISPATCH_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit wait counter is cleared on entry to ATTACK_WAIT and to EVAL_WAIT, and increments every cycle in those states.
  - When the counter reaches TIMEOUT_CYCLES-1 before the completion input is sampled, the block goes to RESULT with res_timeout=1, res_eval=0 and flags 0.
  - The following CLEAR state clears both engines as normal.
- Without the macro: no counter exists, waits are unbounded, and res_timeout is tied to 0.

Test Plan:
- Basic flow:
  - Stimulus: start position, is_attacking_done 5 cycles after attack_board_valid, eval_valid with eval=+37 after 8 cycles, res_ready=1.
  - Required: res_valid for 1 cycle with res_eval=37, then clear_attack=clear_eval=1 for one cycle, then req_ready=1.
- Negative score and flags:
  - Stimulus: eval=-1200, black_in_check=1, insufficient_material=1.
  - Required: res_eval=24'hFFFB50, res_black_in_check=1, res_insufficient=1.
- Backpressure:
  - Stimulus: res_ready held 0 for 20 cycles; req_valid held 1 throughout.
  - Required: res_valid and res_eval stable for 20 cycles, req_ready=0, and no second request accepted until 1 cycle after CLEAR.
- Spurious pulses:
  - Stimulus: eval_valid pulsed during ATTACK_WAIT, and is_attacking_done pulsed in IDLE.
  - Required: no state change and no result.
- Mid-operation reset:
  - Stimulus: reset=0 while in EVAL_WAIT.
  - Required: the same edge drops eval_board_valid to 0, res_valid=0 and req_ready=1.
- Timeout (EVAL_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: eval_valid never asserted.
  - Required: res_valid with res_timeout=1 and res_eval=0, 16 cycles after EVAL_WAIT entry.
